vga_rx_monitor: RTL

Receive-side decoder for the DE1_SoC VGA output (VGA_CLK/HS/VS/BLANK/RGB). It samples the VGA bus on clock_50 and recovers a pixel stream with x/y coordinates. It also produces per-frame checksum/count results and sticky geometry-error flags. It is used on-chip for self-check of the display path and by benches as the display-path scoreboard front end.

---
 rtl/vga_rx_monitor.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_rx_monitor.sv
// Receive-side VGA bus decoder: samples VGA_CLK/HS/VS/BLANK/RGB on clock_50, recovers
// a coordinate-tagged pixel stream, per-frame checksum/count and sticky geometry errors.
module vga_rx_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic        vga_clk,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    input  logic        err_clr,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] pix_rgb,
    output logic        frame_done,
    output logic [31:0] frame_sum,
    output logic [15:0] frame_count,
    output logic        line_err,
    output logic        frame_err
);

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

    state_t      r_state, w_state_nxt;

    logic        r_s1_clk, r_s2_clk, r_s3_clk;
    logic        r_s1_hs, r_s2_hs, r_s1_vs, r_s2_vs, r_s1_blank, r_s2_blank;
    logic [23:0] r_s1_rgb, r_s2_rgb;
    logic        r_hs_prev, r_vs_prev;
    logic        r_pix_p1, r_hsf_p1, r_vsf_p1;
    logic [23:0] r_rgb_p1;

    logic [9:0]  r_x, r_y;
    logic [31:0] r_sum;
    logic        r_pix_valid, r_frame_done, r_line_err, r_frame_err;
    logic [9:0]  r_pix_x, r_pix_y;
    logic [23:0] r_pix_rgb;
    logic [31:0] r_frame_sum;
    logic [15:0] r_frame_count;

    logic        w_tick;
    logic [9:0]  w_x_nxt, w_y_nxt;
    logic [31:0] w_sum_pix, w_sum_nxt;
    logic        w_pix_strobe, w_line_set, w_frame_set, w_frame_end;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    // Stages s1/s2/s3: two-flop capture of the VGA bus, extra flop on vga_clk for edge detect
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_s1_clk   <= 1'b0;
            r_s2_clk   <= 1'b0;
            r_s3_clk   <= 1'b0;
            r_s1_hs    <= 1'b0;
            r_s2_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_s2_vs    <= 1'b0;
            r_s1_blank <= 1'b0;
            r_s2_blank <= 1'b0;
            r_s1_rgb   <= '0;
            r_s2_rgb   <= '0;
        end else begin
            r_s1_clk   <= vga_clk;
            r_s2_clk   <= r_s1_clk;
            r_s3_clk   <= r_s2_clk;
            r_s1_hs    <= vga_hs;
            r_s2_hs    <= r_s1_hs;
            r_s1_vs    <= vga_vs;
            r_s2_vs    <= r_s1_vs;
            r_s1_blank <= vga_blank;
            r_s2_blank <= r_s1_blank;
            r_s1_rgb   <= {vga_r, vga_g, vga_b};
            r_s2_rgb   <= r_s1_rgb;
        end
    end

    assign w_tick = r_s2_clk & ~r_s3_clk;

    // Stage p1: events qualified by the VGA_CLK rising edge
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_hs_prev <= 1'b0;
            r_vs_prev <= 1'b0;
            r_pix_p1  <= 1'b0;
            r_hsf_p1  <= 1'b0;
            r_vsf_p1  <= 1'b0;
            r_rgb_p1  <= '0;
        end else begin
            r_pix_p1 <= w_tick & r_s2_blank;
            r_hsf_p1 <= w_tick & ~r_s2_hs & r_hs_prev;
            r_vsf_p1 <= w_tick & ~r_s2_vs & r_vs_prev;
            r_rgb_p1 <= r_s2_rgb;
            if (w_tick) begin
                r_hs_prev <= r_s2_hs;
                r_vs_prev <= r_s2_vs;
            end
        end
    end

    assign w_sum_pix = r_sum + (r_pix_p1 ? {8'd0, r_rgb_p1} : 32'd0);

    // Same-tick events resolve as pixel, then line close, then frame close
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_sum_nxt    = r_sum;
        w_pix_strobe = 1'b0;
        w_line_set   = 1'b0;
        w_frame_set  = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                if (r_vsf_p1) begin
                    w_state_nxt = ST_LOCKED;
                    w_x_nxt     = 10'd0;
                    w_y_nxt     = 10'd0;
                    w_sum_nxt   = 32'd0;
                end
            end
            ST_LOCKED: begin
                if (r_pix_p1) begin
                    w_pix_strobe = 1'b1;
                    w_x_nxt      = sat_inc(r_x);
                    w_sum_nxt    = w_sum_pix;
                end
                if ((r_hsf_p1 || r_vsf_p1) && (w_x_nxt != 10'd0)) begin
                    w_line_set = (w_x_nxt != 10'(H_ACTIVE));
                    w_y_nxt    = sat_inc(r_y);
                    w_x_nxt    = 10'd0;
                end
                if (r_vsf_p1) begin
                    w_frame_set = (w_y_nxt != 10'(V_ACTIVE));
                    w_frame_end = 1'b1;
                    w_x_nxt     = 10'd0;
                    w_y_nxt     = 10'd0;
                    w_sum_nxt   = 32'd0;
                end
            end
            default: w_state_nxt = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) r_state <= ST_UNLOCKED;
        else       r_state <= w_state_nxt;
    end

    // Stage p2: frame tracking and registered outputs
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_sum         <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_rgb     <= '0;
            r_frame_done  <= 1'b0;
            r_frame_sum   <= '0;
            r_frame_count <= '0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_sum        <= w_sum_nxt;
            r_pix_valid  <= w_pix_strobe;
            r_frame_done <= w_frame_end;
            if (w_pix_strobe) begin
                r_pix_x   <= r_x;
                r_pix_y   <= r_y;
                r_pix_rgb <= r_rgb_p1;
            end
            if (w_frame_end) begin
                r_frame_sum   <= w_sum_pix;
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_line_set)   r_line_err <= 1'b1;
            else if (err_clr) r_line_err <= 1'b0;
            if (w_frame_set)  r_frame_err <= 1'b1;
            else if (err_clr) r_frame_err <= 1'b0;
        end
    end

    assign locked      = (r_state == ST_LOCKED);
    assign pix_valid   = r_pix_valid;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_rgb     = r_pix_rgb;
    assign frame_done  = r_frame_done;
    assign frame_sum   = r_frame_sum;
    assign frame_count = r_frame_count;
    assign line_err    = r_line_err;
    assign frame_err   = r_frame_err;

endmodule
